ocl_axil_reg_bridge: RTL and testbench

AXI-Lite slave front-end for the OCL (AppPF BAR0) path. It sits directly downstream of the OCL AXI-Lite register slice and upstream of the CL register file. It accepts single-beat AXI-Lite reads and writes, with AW and W arriving in any order. Each accepted access is converted into one request on a simple req/ack register bus, and an optional watchdog turns a hung register access into an SLVERR response.

---
 rtl/ocl_axil_reg_bridge.sv | 196 +++++++++++++++++++
 tb/tb_ocl_axil_reg_bridge.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocl_axil_reg_bridge.sv
// ocl_axil_reg_bridge
//   AXI-Lite slave front-end for the OCL (AppPF BAR0) register path. Captures
//   single-beat AXI-Lite reads and writes (AW and W in any order) into
//   one-entry latches. Each access becomes one req/ack transaction on a
//   simple register bus. Reads and writes alternate when both are pending.
//
//   Optional feature macro: OCL_BRIDGE_TIMEOUT_EN
//     When it is defined, a register access that gets no reg_ack within
//     TIMEOUT_CYCLES cycles is completed with SLVERR. Reads return 32'hDEAD_BEEF.
//     When it is undefined, the block waits for reg_ack indefinitely.
//
// Ports
//   clk_main_a0, rst_main_n      clock, async active-low reset
//   s_aw*/s_w*/s_b*              AXI-Lite write address / data / response
//   s_ar*/s_r*                   AXI-Lite read address / data
//   reg_req, reg_wr, reg_addr,   register bus request (level) and payload
//   reg_wdata, reg_wstrb
//   reg_ack, reg_rdata           register bus completion and read data
module ocl_axil_reg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        reg_req,
  output logic        reg_wr,
  output logic [31:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_wstrb,
  input  logic        reg_ack,
  input  logic [31:0] reg_rdata
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_t;

  state_t      state, state_nxt;
  logic        live;
  logic        aw_full, w_full, ar_full;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [3:0]  w_strb_q;
  logic        last_wr;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic        timeout;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;
  assign b_hs  = (state == WR_RESP) & s_bready;
  assign r_hs  = (state == RD_RESP) & s_rready;

  // Keeps all readies low while reset is held and until the first edge after release.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) live <= 1'b0;
    else             live <= 1'b1;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_awaddr;
      end else if (b_hs) begin
        aw_full   <= 1'b0;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end else if (b_hs) begin
        w_full   <= 1'b0;
      end
      if (ar_hs) begin
        ar_full   <= 1'b1;
        ar_addr_q <= s_araddr;
      end else if (r_hs) begin
        ar_full   <= 1'b0;
      end
    end
  end

`ifdef OCL_BRIDGE_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Every request is entered from IDLE, so the count is zero on entry.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n)                              to_cnt <= '0;
    else if (state != WR_REQ && state != RD_REQ) to_cnt <= '0;
    else if (!reg_ack)                            to_cnt <= to_cnt + 16'd1;
  end

  assign timeout = (state == WR_REQ || state == RD_REQ) && !reg_ack &&
                   (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // Tie: serve the type not served last time.
        if (ar_full && (!(aw_full && w_full) || last_wr)) state_nxt = RD_REQ;
        else if (aw_full && w_full)                       state_nxt = WR_REQ;
      end
      WR_REQ:  if (reg_ack || timeout) state_nxt = WR_RESP;
      RD_REQ:  if (reg_ack || timeout) state_nxt = RD_RESP;
      WR_RESP: if (s_bready)           state_nxt = IDLE;
      RD_RESP: if (s_rready)           state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      last_wr <= 1'b1;
      bresp_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && state_nxt == WR_REQ) last_wr <= 1'b1;
      if (state == IDLE && state_nxt == RD_REQ) last_wr <= 1'b0;
      if (state == WR_REQ && (reg_ack || timeout))
        bresp_q <= reg_ack ? 2'b00 : 2'b10;
      if (state == RD_REQ && (reg_ack || timeout)) begin
        rresp_q <= reg_ack ? 2'b00 : 2'b10;
        rdata_q <= reg_ack ? reg_rdata : 32'hDEAD_BEEF;
      end
    end
  end

  always_comb begin
    s_awready = live & ~aw_full;
    s_wready  = live & ~w_full;
    s_arready = live & ~ar_full;
    s_bvalid  = (state == WR_RESP);
    s_rvalid  = (state == RD_RESP);
    s_bresp   = bresp_q;
    s_rresp   = rresp_q;
    s_rdata   = rdata_q;
    reg_req   = 1'b0;
    reg_wr    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_wstrb = '0;
    case (state)
      WR_REQ: begin
        reg_req   = 1'b1;
        reg_wr    = 1'b1;
        reg_addr  = aw_addr_q;
        reg_wdata = w_data_q;
        reg_wstrb = w_strb_q;
      end
      RD_REQ: begin
        reg_req  = 1'b1;
        reg_addr = ar_addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ocl_axil_reg_bridge.sv
module tb_ocl_axil_reg_bridge;
  localparam int unsigned TO = 8;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main_n  = 1'b0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic        s_bready = 1'b0, s_rready = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        reg_req, reg_wr;
  logic [31:0] reg_addr, reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack = 1'b0;
  logic [31:0] reg_rdata = '0;

  always #5 clk_main_a0 = ~clk_main_a0;

  ocl_axil_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } acc_t;

  int          total = 0, bad = 0;
  acc_t        exp_q[$];
  logic [31:0] mem     [0:63];  // register file behind the bus
  logic [31:0] ref_mem [0:63];  // reference model's view of it
  int          ack_delay = 0;
  bit          ack_en = 1'b1, force_ack = 1'b0;
  bit          last_wr_model = 1'b1;
  int          req_seen = 0, req_exp = 0;
  int          req_age = 0;
  bit          ack_given = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a - 32'h500) >> 2) & 63;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask = '0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    return (old & ~mask) | (d & mask);
  endfunction

  // Register-file responder: checks each new request against the expected
  // access order and acks after ack_delay cycles.
  always @(negedge clk_main_a0) begin
    acc_t e;
    if (ack_given) begin
      ack_given = 1'b0;
      check_val("req_drop", 64'(reg_req), 64'd0);
    end
    reg_ack   = force_ack;
    reg_rdata = $urandom;
    if (!reg_req) begin
      req_age = 0;
    end else begin
      if (req_age == 0) begin
        req_seen++;
        check_val("req_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("req_wr", 64'(reg_wr), 64'(e.wr));
          check_val("req_addr", 64'(reg_addr), 64'(e.addr));
          if (e.wr) begin
            check_val("req_wdata", 64'(reg_wdata), 64'(e.wdata));
            check_val("req_wstrb", 64'(reg_wstrb), 64'(e.strb));
          end
        end
      end
      if (ack_en && req_age >= ack_delay) begin
        reg_ack   = 1'b1;
        ack_given = 1'b1;
        if (reg_wr) begin
          for (int b = 0; b < 4; b++)
            if (reg_wstrb[b]) mem[reg_addr[7:2]][8*b +: 8] = reg_wdata[8*b +: 8];
        end else begin
          reg_rdata = mem[reg_addr[7:2]];
        end
      end
      req_age++;
    end
  end

  task automatic wait_b(input int bdly);
    bit seen = 0, hs = 0;
    int idx = 1, first = 0;
    while (!hs && idx < 300) begin
      if (s_bvalid && !seen) begin
        seen = 1; first = idx;
        check_val("b_lat", 64'(idx), 64'(2 + ack_delay));
      end
      s_bready = seen && (idx - first >= bdly);
      hs = s_bvalid && s_bready;
      if (hs) check_val("bresp", 64'(s_bresp), 64'd0);
      @(negedge clk_main_a0);
      idx++;
    end
    s_bready = 1'b0;
    check_val("b_done", 64'(hs), 64'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_at, input int w_at, input int bdly);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int c = 0;
    acc_t e;
    e.wr = 1; e.addr = a; e.wdata = d; e.strb = s;
    exp_q.push_back(e);
    req_exp++;
    ref_mem[midx(a)] = merge(ref_mem[midx(a)], d, s);
    last_wr_model = 1'b1;
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    while (!(aw_done && w_done) && c < 50) begin
      s_awvalid = !aw_done && c >= aw_at;
      s_wvalid  = !w_done && c >= w_at;
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      @(negedge clk_main_a0);
      aw_done |= aw_fire;
      w_done  |= w_fire;
      c++;
      if (w_done && !aw_done) begin
        check_val("wfirst_wready", 64'(s_wready), 64'd0);
        check_val("wfirst_awready", 64'(s_awready), 64'd1);
        check_val("wfirst_noreq", 64'(reg_req), 64'd0);
      end
      if (aw_done && !w_done) begin
        check_val("awfirst_awready", 64'(s_awready), 64'd0);
        check_val("awfirst_wready", 64'(s_wready), 64'd1);
      end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check_val("aw_w_accept", 64'(aw_done && w_done), 64'd1);
    check_val("wr_req_early", 64'(reg_req), 64'd0);
    @(negedge clk_main_a0);
    check_val("wr_req_rise", 64'(reg_req), 64'd1);
    wait_b(bdly);
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly);
    bit fire, done = 0, seen = 0, hs = 0;
    int c = 0, idx = 1, first = 0;
    logic [31:0] expv;
    acc_t e;
    e.wr = 0; e.addr = a; e.wdata = '0; e.strb = '0;
    exp_q.push_back(e);
    req_exp++;
    expv = ref_mem[midx(a)];
    last_wr_model = 1'b0;
    s_araddr = a;
    while (!done && c < 50) begin
      s_arvalid = 1'b1;
      fire = s_arready;
      @(negedge clk_main_a0);
      done = fire;
      c++;
    end
    s_arvalid = 1'b0;
    check_val("ar_accept", 64'(done), 64'd1);
    check_val("rd_req_early", 64'(reg_req), 64'd0);
    @(negedge clk_main_a0);
    check_val("rd_req_rise", 64'(reg_req), 64'd1);
    while (!hs && idx < 300) begin
      if (s_rvalid && !seen) begin
        seen = 1; first = idx;
        check_val("r_lat", 64'(idx), 64'(2 + ack_delay));
      end
      if (s_rvalid) check_val("rdata", 64'(s_rdata), 64'(expv));
      s_rready = seen && (idx - first >= rdly);
      hs = s_rvalid && s_rready;
      if (hs) check_val("rresp", 64'(s_rresp), 64'd0);
      @(negedge clk_main_a0);
      idx++;
    end
    s_rready = 1'b0;
    check_val("r_done", 64'(hs), 64'd1);
  endtask

  task automatic tie_pair(input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] ra);
    bit rd_first, awd = 0, wd = 0, ard = 0, af, wf, rf, rdone = 0, bdone = 0;
    int c = 0, idx = 0, r_idx = 0, b_idx = 0;
    logic [31:0] rexp;
    acc_t ew, er;
    ew.wr = 1; ew.addr = wa; ew.wdata = d;  ew.strb = s;
    er.wr = 0; er.addr = ra; er.wdata = '0; er.strb = '0;
    rd_first = last_wr_model;
    if (rd_first) begin
      rexp = ref_mem[midx(ra)];
      ref_mem[midx(wa)] = merge(ref_mem[midx(wa)], d, s);
      exp_q.push_back(er); exp_q.push_back(ew);
    end else begin
      ref_mem[midx(wa)] = merge(ref_mem[midx(wa)], d, s);
      rexp = ref_mem[midx(ra)];
      exp_q.push_back(ew); exp_q.push_back(er);
    end
    last_wr_model = rd_first;
    req_exp += 2;
    s_awaddr = wa; s_wdata = d; s_wstrb = s; s_araddr = ra;
    while (!(awd && wd && ard) && c < 50) begin
      s_awvalid = !awd; s_wvalid = !wd; s_arvalid = !ard;
      af = s_awvalid && s_awready;
      wf = s_wvalid && s_wready;
      rf = s_arvalid && s_arready;
      @(negedge clk_main_a0);
      awd |= af; wd |= wf; ard |= rf;
      c++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check_val("tie_accept_cycles", 64'(c), 64'd1);
    s_bready = 1'b1; s_rready = 1'b1;
    while (!(rdone && bdone) && idx < 300) begin
      if (s_rvalid && !rdone) begin
        rdone = 1; r_idx = idx;
        check_val("tie_rdata", 64'(s_rdata), 64'(rexp));
        check_val("tie_rresp", 64'(s_rresp), 64'd0);
      end
      if (s_bvalid && !bdone) begin
        bdone = 1; b_idx = idx;
        check_val("tie_bresp", 64'(s_bresp), 64'd0);
      end
      @(negedge clk_main_a0);
      idx++;
    end
    s_bready = 1'b0; s_rready = 1'b0;
    check_val("tie_both_done", 64'(rdone && bdone), 64'd1);
    check_val("tie_order", 64'(r_idx < b_idx), 64'(rd_first));
  endtask

  task automatic rst_mid_write();
    int n = 0, nb = 0;
    acc_t e;
    ack_en = 1'b0;
    e.wr = 1; e.addr = 32'h520; e.wdata = 32'hA5A5_0F0F; e.strb = 4'hF;
    exp_q.push_back(e);
    req_exp++;
    s_awaddr = e.addr; s_wdata = e.wdata; s_wstrb = e.strb;
    check_val("rst_pre_ready", 64'({s_awready, s_wready}), 64'd3);
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk_main_a0);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    while (!reg_req && n < 10) begin
      @(negedge clk_main_a0);
      n++;
    end
    check_val("rst_req_seen", 64'(reg_req), 64'd1);
    #2 rst_main_n = 1'b0;
    #1;
    check_val("rst_async_req", 64'(reg_req), 64'd0);
    check_val("rst_async_addr", 64'({reg_wr, reg_addr, reg_wdata, reg_wstrb}), 64'd0);
    check_val("rst_async_ready", 64'({s_awready, s_wready, s_arready}), 64'd0);
    check_val("rst_async_valid", 64'({s_bvalid, s_rvalid}), 64'd0);
    last_wr_model = 1'b1;
    @(negedge clk_main_a0);
    @(negedge clk_main_a0);
    rst_main_n = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_main_a0);
      nb += int'(s_bvalid);
    end
    check_val("rst_no_bvalid", 64'(nb), 64'd0);
    check_val("rst_ready_back", 64'({s_awready, s_wready, s_arready}), 64'd7);
  endtask

`ifdef OCL_BRIDGE_TIMEOUT_EN
  task automatic timeout_read();
    int n_req = 0, idx = 0;
    acc_t e;
    ack_en = 1'b0;
    e.wr = 0; e.addr = 32'h508; e.wdata = '0; e.strb = '0;
    exp_q.push_back(e);
    req_exp++;
    last_wr_model = 1'b0;
    s_araddr = e.addr;
    s_arvalid = 1'b1;
    @(negedge clk_main_a0);
    s_arvalid = 1'b0;
    while (!s_rvalid && idx < 100) begin
      if (reg_req) n_req++;
      @(negedge clk_main_a0);
      idx++;
    end
    check_val("to_req_cycles", 64'(n_req), 64'(TO));
    check_val("to_rresp", 64'(s_rresp), 64'd2);
    check_val("to_rdata", 64'(s_rdata), 64'h0000_0000_DEAD_BEEF);
    force_ack = 1'b1;
    @(negedge clk_main_a0);
    @(negedge clk_main_a0);
    force_ack = 1'b0;
    @(negedge clk_main_a0);
    @(negedge clk_main_a0);
    check_val("to_late_rvalid", 64'(s_rvalid), 64'd1);
    check_val("to_late_rdata", 64'(s_rdata), 64'h0000_0000_DEAD_BEEF);
    check_val("to_late_rresp", 64'(s_rresp), 64'd2);
    check_val("to_late_noreq", 64'(reg_req), 64'd0);
    s_rready = 1'b1;
    @(negedge clk_main_a0);
    s_rready = 1'b0;
    check_val("to_r_done", 64'(s_rvalid), 64'd0);
    ack_en = 1'b1;
  endtask
`endif

  task automatic random_ops(input int n);
    int k;
    logic [31:0] a, a2;
    for (int i = 0; i < n; i++) begin
      ack_delay = int'($urandom_range(0, 4));
      k  = int'($urandom_range(0, 2));
      a  = 32'h500 + ($urandom_range(0, 15) << 2);
      a2 = 32'h500 + ($urandom_range(0, 15) << 2);
      case (k)
        0: do_write(a, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        1: do_read(a, int'($urandom_range(0, 3)));
        default: tie_pair(a, $urandom, 4'($urandom_range(1, 15)), a2);
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #12;
    check_val("rst_ready", 64'({s_awready, s_wready, s_arready}), 64'd0);
    check_val("rst_valid", 64'({s_bvalid, s_rvalid}), 64'd0);
    check_val("rst_reg", 64'({reg_req, reg_wr, reg_wstrb, reg_addr}), 64'd0);
    check_val("rst_reg_wdata", 64'(reg_wdata), 64'd0);
    check_val("rst_resp", 64'({s_bresp, s_rresp}), 64'd0);
    check_val("rst_rdata", 64'(s_rdata), 64'd0);
    @(negedge clk_main_a0);
    rst_main_n = 1'b1;
    @(negedge clk_main_a0);
    @(negedge clk_main_a0);

    ack_delay = 1;
    tie_pair(32'h510, 32'h1111_2222, 4'hF, 32'h514);
    tie_pair(32'h518, 32'h3333_4444, 4'h3, 32'h510);

    ack_delay = 0;
    do_write(32'h500, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_write(32'h50C, 32'h0BAD_F00D, 4'h5, 3, 0, 1);

    mem[1] = 32'hCAFE_0001;
    ref_mem[1] = 32'hCAFE_0001;
    ack_delay = 4;
    do_read(32'h504, 3);

    random_ops(40);
    rst_mid_write();
    ack_delay = 0;
    tie_pair(32'h53C, 32'hFEED_0000, 4'hC, 32'h53C);
`ifdef OCL_BRIDGE_TIMEOUT_EN
    timeout_read();
`endif
    random_ops(10);

    repeat (3) @(negedge clk_main_a0);
    check_val("req_count", 64'(req_seen), 64'(req_exp));
    check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
